regfile_access_arbiter: RTL

Shares one 1-write/2-read register file (registered reads, one-cycle latency) among NUM_REQ client requesters. Each cycle it grants up to one write and up to two reads using a single rotating round-robin priority pointer. It drives the register file's port signals and routes the returned read data back to the issuing client. It sits between the issue/agent logic and the register file.

---
 rtl/regfile_arb_pkg.sv | 49 ++++
 rtl/regfile_access_arbiter_if.sv | 53 +++++
 rtl/regfile_access_arbiter_rr_scan.sv | 32 +++
 rtl/regfile_access_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared types and helpers for regfile_access_arbiter.
//   lane_id_t   - registered per-lane response tag (valid + client id)
//   rr_pick_t   - result of a rotating priority scan
//   rr_pick()   - rotating priority pick over a client mask starting at ptr
package regfile_arb_pkg;

    // Upper bound on the number of clients; sizes the package-level types.
    localparam int unsigned MaxNumReq  = 16;
    localparam int unsigned MaxIdWidth = $clog2(MaxNumReq);

    typedef struct packed {
        logic                  valid;
        logic [MaxIdWidth-1:0] id;
    } lane_id_t;

    typedef struct packed {
        logic                  found;
        logic [MaxNumReq-1:0]  onehot;
        logic [MaxIdWidth-1:0] idx;
        logic [MaxIdWidth-1:0] offset;  // scan distance from ptr to idx
    } rr_pick_t;

    // Returns the first set bit of valid_mask in the order ptr, ptr+1, ... (mod num_req).
    function automatic rr_pick_t rr_pick(input logic [MaxNumReq-1:0]  valid_mask,
                                         input logic [MaxIdWidth-1:0] ptr,
                                         input int unsigned           num_req);
        rr_pick_t              res;
        logic [MaxIdWidth:0]   pos;
        res = '0;
        pos = '0;
        for (int unsigned i = 0; i < MaxNumReq; i++) begin
            if (i < num_req && !res.found) begin
                // ptr < num_req and i < num_req, so one subtraction wraps the position.
                pos = {1'b0, ptr} + (MaxIdWidth + 1)'(i);
                if (pos >= (MaxIdWidth + 1)'(num_req)) begin
                    pos = pos - (MaxIdWidth + 1)'(num_req);
                end
                if (valid_mask[pos[MaxIdWidth-1:0]]) begin
                    res.found                       = 1'b1;
                    res.onehot[pos[MaxIdWidth-1:0]] = 1'b1;
                    res.idx                         = pos[MaxIdWidth-1:0];
                    res.offset                      = MaxIdWidth'(i);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// regfile_access_arbiter_if: bundle between clients, the arbiter and the register file.
//   req_*        client requests (valid, op, packed addr, packed write data) and grants
//   rsp_*        two read-response lanes back to the clients
//   rf_*         register file write port, two read ports and registered read data
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (clients plus the register file)
interface regfile_access_arbiter_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0]            req_ready;

    logic [NUM_REQ-1:0]            rsp_valid;
    logic [WIDTH-1:0]              rsp_rdata;
    logic [NUM_REQ-1:0]            rsp_valid2;
    logic [WIDTH-1:0]              rsp_rdata2;

    logic                          rf_write_en;
    logic [ADDR_WIDTH-1:0]         rf_write_addr;
    logic [WIDTH-1:0]              rf_write_data;
    logic                          rf_read_en1;
    logic [ADDR_WIDTH-1:0]         rf_read_addr1;
    logic                          rf_read_en2;
    logic [ADDR_WIDTH-1:0]         rf_read_addr2;
    logic [WIDTH-1:0]              rf_read_data1;
    logic [WIDTH-1:0]              rf_read_data2;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rf_read_data1, rf_read_data2,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_valid2, rsp_rdata2,
        output rf_write_en, rf_write_addr, rf_write_data,
        output rf_read_en1, rf_read_addr1, rf_read_en2, rf_read_addr2
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output rf_read_data1, rf_read_data2,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_valid2, rsp_rdata2,
        input  rf_write_en, rf_write_addr, rf_write_data,
        input  rf_read_en1, rf_read_addr1, rf_read_en2, rf_read_addr2
    );

endinterface

// File: rtl/regfile_access_arbiter_rr_scan.sv
// regfile_access_arbiter_rr_scan: combinational rotating priority encoder (rr_scan).
//   mask_i    candidate clients
//   ptr_i     client with highest priority this cycle
//   found_o   some candidate was selected
//   onehot_o  selected client, one-hot
//   idx_o     selected client index
//   offset_o  scan distance from ptr_i to the selected client
module regfile_access_arbiter_rr_scan
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  mask_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic                found_o,
    output logic [NUM_REQ-1:0]  onehot_o,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic [ID_WIDTH-1:0] offset_o
);

    rr_pick_t pick;

    always_comb begin
        pick     = rr_pick(MaxNumReq'(mask_i), MaxIdWidth'(ptr_i), NUM_REQ);
        found_o  = pick.found;
        onehot_o = NUM_REQ'(pick.onehot);
        idx_o    = ID_WIDTH'(pick.idx);
        offset_o = ID_WIDTH'(pick.offset);
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: shares one 1W/2R register file (registered reads) among NUM_REQ
// clients. Each cycle grants up to one write and two reads from a single rotating
// round-robin pointer and routes the read data back one cycle later.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    regfile_access_arbiter_if.slave (client requests/responses, register file ports)
// Optional feature macro: REGFILE_ARB_BYPASS_EN - a read granted together with a write to
// the same address returns the new write data instead of the old register contents.
module regfile_access_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input logic                     clk,
    input logic                     rst_n,
    regfile_access_arbiter_if.slave bus
);

    localparam int unsigned SumWidth = ID_WIDTH + 1;

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    lane_id_t              lane1_q, lane1_d;
    lane_id_t              lane2_q, lane2_d;

    logic [NUM_REQ-1:0]    wr_mask, rd_mask, rd2_mask;
    logic                  w_found, r1_found, r2_found;
    logic [NUM_REQ-1:0]    w_onehot, r1_onehot, r2_onehot;
    logic [ID_WIDTH-1:0]   w_idx, r1_idx, r2_idx;
    logic [ID_WIDTH-1:0]   w_off, r1_off, r2_off;
    logic                  gnt_w, gnt_r1, gnt_r2;
    logic [ID_WIDTH-1:0]   max_off;
    logic [SumWidth-1:0]   ptr_sum;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]      wdata_arr [NUM_REQ];
    logic [WIDTH-1:0]      rdata1, rdata2;
    logic [ID_WIDTH-1:0]   lane1_id, lane2_id;
    logic                  rsp_v1, rsp_v2;

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = bus.req_wdata[i*WIDTH +: WIDTH];
        end
    end

    assign wr_mask  = bus.req_valid & bus.req_write;
    assign rd_mask  = bus.req_valid & ~bus.req_write;
    // Second read port takes the next reader after the port-1 winner.
    assign rd2_mask = rd_mask & ~r1_onehot;

    regfile_access_arbiter_rr_scan #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_scan_wr (
        .mask_i   (wr_mask),
        .ptr_i    (rr_ptr_q),
        .found_o  (w_found),
        .onehot_o (w_onehot),
        .idx_o    (w_idx),
        .offset_o (w_off)
    );

    regfile_access_arbiter_rr_scan #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_scan_rd1 (
        .mask_i   (rd_mask),
        .ptr_i    (rr_ptr_q),
        .found_o  (r1_found),
        .onehot_o (r1_onehot),
        .idx_o    (r1_idx),
        .offset_o (r1_off)
    );

    regfile_access_arbiter_rr_scan #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_scan_rd2 (
        .mask_i   (rd2_mask),
        .ptr_i    (rr_ptr_q),
        .found_o  (r2_found),
        .onehot_o (r2_onehot),
        .idx_o    (r2_idx),
        .offset_o (r2_off)
    );

    // No grants at all while reset is asserted.
    assign gnt_w  = rst_n & w_found;
    assign gnt_r1 = rst_n & r1_found;
    assign gnt_r2 = rst_n & r2_found;

    assign bus.req_ready = rst_n ? (w_onehot | r1_onehot | r2_onehot) : '0;

    // Register file ports; idle ports are driven to zero.
    always_comb begin
        bus.rf_write_en   = gnt_w;
        bus.rf_write_addr = gnt_w ? addr_arr[w_idx] : '0;
        bus.rf_write_data = gnt_w ? wdata_arr[w_idx] : '0;
        bus.rf_read_en1   = gnt_r1;
        bus.rf_read_addr1 = gnt_r1 ? addr_arr[r1_idx] : '0;
        bus.rf_read_en2   = gnt_r2;
        bus.rf_read_addr2 = gnt_r2 ? addr_arr[r2_idx] : '0;
    end

    // Pointer moves just past the granted client furthest along the scan order.
    always_comb begin
        max_off = '0;
        if (gnt_w) begin
            max_off = w_off;
        end
        if (gnt_r1 && r1_off > max_off) begin
            max_off = r1_off;
        end
        if (gnt_r2 && r2_off > max_off) begin
            max_off = r2_off;
        end
        ptr_sum = SumWidth'(rr_ptr_q) + SumWidth'(max_off) + SumWidth'(1);
        if (ptr_sum >= SumWidth'(NUM_REQ)) begin
            ptr_sum = ptr_sum - SumWidth'(NUM_REQ);
        end
        rr_ptr_d = (gnt_w || gnt_r1 || gnt_r2) ? ID_WIDTH'(ptr_sum) : rr_ptr_q;
    end

    always_comb begin
        lane1_d.valid = gnt_r1;
        lane1_d.id    = MaxIdWidth'(r1_idx);
        lane2_d.valid = gnt_r2;
        lane2_d.id    = MaxIdWidth'(r2_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            lane1_q  <= '0;
            lane2_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lane1_q  <= lane1_d;
            lane2_q  <= lane2_d;
        end
    end

`ifdef REGFILE_ARB_BYPASS_EN
    logic             fwd1_q, fwd1_d;
    logic             fwd2_q, fwd2_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

    always_comb begin
        fwd1_d     = gnt_w && gnt_r1 && (addr_arr[w_idx] == addr_arr[r1_idx]);
        fwd2_d     = gnt_w && gnt_r2 && (addr_arr[w_idx] == addr_arr[r2_idx]);
        fwd_data_d = wdata_arr[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd1_q     <= 1'b0;
            fwd2_q     <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd1_q     <= fwd1_d;
            fwd2_q     <= fwd2_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rdata1 = fwd1_q ? fwd_data_q : bus.rf_read_data1;
    assign rdata2 = fwd2_q ? fwd_data_q : bus.rf_read_data2;
`else
    assign rdata1 = bus.rf_read_data1;
    assign rdata2 = bus.rf_read_data2;
`endif

    // Responses are suppressed while reset is held, dropping a read granted just before.
    always_comb begin
        lane1_id       = ID_WIDTH'(lane1_q.id);
        lane2_id       = ID_WIDTH'(lane2_q.id);
        rsp_v1         = rst_n & lane1_q.valid;
        rsp_v2         = rst_n & lane2_q.valid;
        bus.rsp_valid  = '0;
        bus.rsp_valid2 = '0;
        if (rsp_v1) begin
            bus.rsp_valid[lane1_id] = 1'b1;
        end
        if (rsp_v2) begin
            bus.rsp_valid2[lane2_id] = 1'b1;
        end
        bus.rsp_rdata  = rsp_v1 ? rdata1 : '0;
        bus.rsp_rdata2 = rsp_v2 ? rdata2 : '0;
    end

endmodule
